// File: rtl/pipe_alu.sv
// Two-stage valid/ready ALU: operand register, then result/flag register.
// Sticky NZVC flags update when a flag-setting result is consumed.
module pipe_alu #(
  parameter int WIDTH     = 64,
  parameter int FLAG_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ctrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carryOut,
  output logic [3:0]       nzcv
);

  localparam int SW = $clog2(WIDTH);

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_ctrl;
  logic             s1_sf;
  logic             s2_sf;
  logic             s2_load;
  logic             consume;

  logic [WIDTH-1:0] bop;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             msb_cin;
  logic             arith;
  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_c;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_load;
  assign consume  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_ctrl <= 3'b000;
      s1_sf   <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= A;
        s1_b    <= B;
        s1_ctrl <= ctrl;
        s1_sf   <= set_flags;
      end
    end
  end

  // ctrl[0] selects subtract: invert B and use it as carry-in
  assign cin = s1_ctrl[0];
  assign bop = cin ? ~s1_b : s1_b;
  assign sum = {1'b0, s1_a} + {1'b0, bop}
             + {{WIDTH{1'b0}}, cin};
  assign msb_cin = sum[WIDTH-1] ^ s1_a[WIDTH-1]
                 ^ bop[WIDTH-1];
  assign arith = (s1_ctrl[2:1] == 2'b01);

  always_comb begin
    res = '0;
    unique case (s1_ctrl)
      3'b000: res = s1_b;
      3'b001: res = s1_a;
      3'b010: res = sum[WIDTH-1:0];
      3'b011: res = sum[WIDTH-1:0];
      3'b100: res = s1_a & s1_b;
      3'b101: res = s1_a | s1_b;
      3'b110: res = s1_a ^ s1_b;
      3'b111: res = s1_a << s1_b[SW-1:0];
      default: res = '0;
    endcase
  end

  assign res_c = arith & sum[WIDTH];
  assign res_v = arith & (msb_cin ^ sum[WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      aluOut    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carryOut  <= 1'b0;
      s2_sf     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_v;
      if (s1_v) begin
        aluOut   <= res;
        negative <= res[WIDTH-1];
        zero     <= (res == '0);
        overflow <= res_v;
        carryOut <= res_c;
        s2_sf    <= s1_sf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv <= 4'b0000;
    end else if ((FLAG_HOLD != 0) && consume && s2_sf) begin
      nzcv <= {negative, zero, overflow, carryOut};
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Randomized bench for pipe_alu against a queue-based reference model.
// Also exercises an 8-bit build without the sticky flag register.
module tb_pipe_alu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic [2:0]   ctrl;
  logic         set_flags;
  logic         out_valid, out_ready;
  logic [W-1:0] aluOut;
  logic         negative, zero, overflow, carryOut;
  logic [3:0]   nzcv;

  logic         iv8, ir8, ov8, or8, sf8;
  logic [7:0]   a8, b8, r8;
  logic [2:0]   c8;
  logic         n8, z8, v8, cy8;
  logic [3:0]   nzcv8;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(W), .FLAG_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ctrl(ctrl), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluOut(aluOut), .negative(negative), .zero(zero),
    .overflow(overflow), .carryOut(carryOut), .nzcv(nzcv)
  );

  pipe_alu #(.WIDTH(8), .FLAG_HOLD(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .ctrl(c8), .set_flags(sf8),
    .out_valid(ov8), .out_ready(or8),
    .aluOut(r8), .negative(n8), .zero(z8),
    .overflow(v8), .carryOut(cy8), .nzcv(nzcv8)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   f;
    logic         sf;
    int           t;
  } exp_t;

  exp_t         q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [W-1:0] last_res;
  logic [3:0]   last_f;
  logic [3:0]   m_nzcv;
  logic         last_acc;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [2:0] c,
                                 input logic sf);
    exp_t e;
    logic [W:0] s;
    logic vf, cf;
    vf = 1'b0;
    cf = 1'b0;
    e.res = '0;
    case (c)
      3'd0: e.res = b;
      3'd1: e.res = a;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        cf = s[W];
        vf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd3: begin
        e.res = a - b;
        cf = (a >= b);
        vf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd4: e.res = a & b;
      3'd5: e.res = a | b;
      3'd6: e.res = a ^ b;
      default: e.res = a << b[5:0];
    endcase
    e.f  = {e.res[W-1], e.res == '0, vf, cf};
    e.sf = sf;
    e.t  = 0;
    return e;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [2:0] c,
                      input logic sf, input logic ordy);
    logic exp_ir, exp_ov, cons;
    exp_t e;
    in_valid = iv; A = a; B = b; ctrl = c;
    set_flags = sf; out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    exp_ir = !((q.size() == 2) && !ordy);
    chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
    chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
    if (exp_ov) begin
      chk("result", aluOut, q[0].res);
      chk("flags", {60'b0, negative, zero, overflow, carryOut},
          {60'b0, q[0].f});
    end else begin
      chk("hold_res", aluOut, last_res);
      chk("hold_flags", {60'b0, negative, zero, overflow, carryOut},
          {60'b0, last_f});
    end
    cons = exp_ov && ordy;
    last_acc = iv && exp_ir;
    @(posedge clk);
    cyc++;
    if (cons) begin
      e = q.pop_front();
      last_res = e.res;
      last_f = e.f;
      if (e.sf) m_nzcv = e.f;
    end
    if (last_acc) begin
      e = model(a, b, c, sf);
      e.t = cyc - 1;
      q.push_back(e);
    end
    #1;
    chk("nzcv", {60'b0, nzcv}, {60'b0, m_nzcv});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
    chk("drain_empty", q.size(), 0);
    idle(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ov", {63'b0, out_valid}, 64'd0);
    chk("rst_out", aluOut, 64'd0);
    chk("rst_flags", {60'b0, negative, zero, overflow, carryOut}, 64'd0);
    chk("rst_nzcv", {60'b0, nzcv}, 64'd0);
    chk("rst_ir", {63'b0, in_ready}, 64'd1);
    q.delete();
    last_res = '0;
    last_f = 4'b0;
    m_nzcv = 4'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] sp[4];
    sp[0] = '0;
    sp[1] = '1;
    sp[2] = 64'h8000_0000_0000_0000;
    sp[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    int acc;
    rst_n = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; ctrl = 3'd0;
    set_flags = 1'b0; out_ready = 1'b0;
    iv8 = 1'b0; a8 = 8'h0; b8 = 8'h0; c8 = 3'd0;
    sf8 = 1'b0; or8 = 1'b0;
    last_res = '0; last_f = 4'b0; m_nzcv = 4'b0;
    @(negedge clk);
    do_reset();

    // signed overflow on add, sticky flags latch on consume
    step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b1);
    drain();
    chk("nzcv_ovf", {60'b0, nzcv}, 64'b1010);

    step(1'b1, 64'd5, 64'd5, 3'b011, 1'b0, 1'b1);
    drain();
    chk("nzcv_kept", {60'b0, nzcv}, 64'b1010);

    step(1'b1, 64'hF0, 64'h3C, 3'b100, 1'b0, 1'b1);
    step(1'b1, 64'hF0, 64'h3C, 3'b101, 1'b0, 1'b1);
    step(1'b1, 64'hF0, 64'h3C, 3'b110, 1'b0, 1'b1);
    drain();

    step(1'b1, 64'd1, 64'h43, 3'b111, 1'b1, 1'b1);
    drain();
    chk("shift_res", last_res, 64'h8);

    // back-pressure: only two operations fit in the pipe
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'd100 + 64'(i), 64'd7, 3'b010, 1'b0, 1'b0);
      if (last_acc) acc++;
    end
    chk("bp_accepts", acc, 2);
    drain();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_op(), rand_op(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7);
    drain();

    step(1'b1, 64'd1, 64'd2, 3'b010, 1'b1, 1'b0);
    step(1'b1, 64'd3, 64'd4, 3'b010, 1'b1, 1'b0);
    step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    chk("inflight", q.size(), 2);
    do_reset();
    idle(6);

    in_valid = 1'b0;
    iv8 = 1'b1; a8 = 8'h81; b8 = 8'h01; c8 = 3'b010;
    sf8 = 1'b1; or8 = 1'b1;
    #1;
    chk("w8_ir", {63'b0, ir8}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    #1;
    chk("w8_ov", {63'b0, ov8}, 64'd1);
    chk("w8_res", {56'b0, r8}, 64'h82);
    chk("w8_flags", {60'b0, n8, z8, v8, cy8}, 64'b1000);
    @(posedge clk);
    #1;
    chk("w8_nzcv", {60'b0, nzcv8}, 64'd0);
    chk("w8_done", {63'b0, ov8}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 64: datapath width in bits; legal values 8..64, multiple of 8.
REQ-002 Parameter FLAG_HOLD, default 1: 1 = sticky NZVC register present; 0 = sticky register outputs tied to 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  pipe_alu accepts the offered operation this cycle.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 ctrl  input  3  opcode.
REQ-010 set_flags  input  1  operation updates the sticky flags.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 aluOut  output  WIDTH  result.
REQ-014 negative, zero, overflow, carryOut  output  1 each  flags of the presented result.
REQ-015 nzcv  output  4  sticky flags {N,Z,V,C}.

Function
REQ-016 Opcodes SHALL be: 000 pass B; 001 pass A; 010 A+B; 011 A+~B+1; 100 A&B; 101 A|B; 110 A^B; 111 A shifted left by B[log2(WIDTH)-1:0], zero fill.
REQ-017 The adder SHALL use carry-in = ctrl[0] for opcodes 010/011.
REQ-018 carryOut SHALL be the adder MSB carry-out for 010/011 (sub: 1 = no borrow), else 0.
REQ-019 overflow SHALL be the MSB carry-in XOR MSB carry-out for 010/011, else 0.
REQ-020 negative SHALL be aluOut[WIDTH-1]; zero SHALL be 1 iff aluOut is all zeros; both valid for every opcode.
REQ-021 Two-stage pipeline: stage 1 registers A, B, ctrl, set_flags on accept; stage 2 registers result and flags.
REQ-022 An operation is accepted when in_valid && in_ready; its result SHALL assert out_valid exactly 2 cycles later when there is no back-pressure.
REQ-023 A result is consumed when out_valid && out_ready.
REQ-024 Stage 2 SHALL load when it is empty or is consumed this cycle; stage 1 SHALL load when it is empty or moves to stage 2 this cycle.
REQ-025 in_ready SHALL be combinational: stage 1 empty OR stage 1 advances this cycle; it SHALL NOT depend on in_valid.
REQ-026 Full throughput SHALL be sustained with out_ready held 1: one accept and one consume per cycle.
REQ-027 While out_valid=1 and out_ready=0, aluOut and all flag outputs SHALL hold stable, and no operation SHALL be lost or duplicated; at most 2 operations are in flight.
REQ-028 Results SHALL emerge in acceptance order.
REQ-029 With FLAG_HOLD=1, nzcv SHALL load {negative,zero,overflow,carryOut} on the cycle a result with set_flags=1 is consumed; otherwise it holds.
REQ-030 When out_valid=0, aluOut and the flag outputs SHALL hold their last values.

Reset
REQ-031 On rst_n=0: both stages empty, out_valid=0, aluOut=0, negative=0, zero=0, overflow=0, carryOut=0, nzcv=0, all asynchronously.
REQ-032 in_ready SHALL be 1 while rst_n=0 and on the first cycle after release.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; no result SHALL be presented for them after release.

Verification
REQ-034 WIDTH=64; A=0x7FFF_FFFF_FFFF_FFFF, B=1, ctrl=010, set_flags=1 -> after 2 cycles: aluOut=0x8000_0000_0000_0000, N=1, Z=0, V=1, C=0; nzcv=1010 after consume.
REQ-035 A=5, B=5, ctrl=011 -> aluOut=0, Z=1, C=1, V=0; with set_flags=0, nzcv is unchanged.
REQ-036 Three back-to-back accepts (ctrl 100, 101, 110; A=0xF0, B=0x3C) with out_ready=1 -> results 0x30, 0xFC, 0xCC on consecutive cycles.
REQ-037 out_ready=0 for 5 cycles with in_valid held 1 -> exactly 2 accepts and then in_ready=0; outputs stay stable; on release the results drain in order, with no loss or duplication.
REQ-038 ctrl=111, A=1, B=0x43 (WIDTH=64) -> aluOut=0x8, C=0, V=0; WIDTH=8 build: A=0x81, B=1, ctrl=010 -> 0x82.
REQ-039 rst_n low for one cycle with 2 operations in flight -> out_valid=0 and all outputs 0 immediately; no stale results after release.
